// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder wrapped around one external combinational full-adder cell.
// Optional SERIAL_ADD_SUB_EN adds an i_sub input selecting A-B (two's complement).
module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin0,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_fa_a,
  output logic             o_fa_b,
  output logic             o_fa_cin,
  input  logic             i_fa_s,
  input  logic             i_fa_cout,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_carry;
  logic             r_msb_cin;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic [WIDTH-1:0] w_b_load;
  logic             w_cin_load;
  logic             w_last;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is A + ~B + 1; Cin0 is irrelevant in that mode.
  assign w_b_load   = i_sub ? ~i_b : i_b;
  assign w_cin_load = i_sub ? 1'b1 : i_cin0;
`else
  assign w_b_load   = i_b;
  assign w_cin_load = i_cin0;
`endif

  assign w_last = (r_count == LAST_BIT);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_fa_a       = 1'b0;
    o_fa_b       = 1'b0;
    o_fa_cin     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        o_busy   = 1'b1;
        o_fa_a   = r_a_sh[0];
        o_fa_b   = r_b_sh[0];
        o_fa_cin = r_carry;
        if (w_last) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        o_done       = 1'b1;
        w_next_state = i_start ? ST_SHIFT : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, matching the hardware.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_s_sh    <= '0;
      r_carry   <= 1'b0;
      r_msb_cin <= 1'b0;
      r_s       <= '0;
      r_cout    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_a_sh  <= i_a;
            r_b_sh  <= w_b_load;
            r_carry <= w_cin_load;
            r_count <= '0;
          end
        end
        ST_SHIFT: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_s_sh  <= {i_fa_s, r_s_sh[WIDTH-1:1]};
          r_carry <= i_fa_cout;
          r_count <= r_count + CNT_W'(1);
          if (w_last) begin
            // Carry into the MSB is kept alongside Cout so overflow stays a function of result flops only.
            r_msb_cin <= r_carry;
            r_s       <= {i_fa_s, r_s_sh[WIDTH-1:1]};
            r_cout    <= i_fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_s        = r_s;
  assign o_cout     = r_cout;
  assign o_overflow = r_msb_cin ^ r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: provides the full-adder cell and compares
// against an arithmetic reference model (sum, carry chain, signed overflow).
module tb_serial_add_seq;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin0;
  logic             sub;
  logic             fa_a, fa_b, fa_cin, fa_s, fa_cout;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] s_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] last_s;
  logic             last_cout;
  logic             last_ovf;

  always #5 clk = ~clk;

  // The external full-adder cell.
  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_a        (a_in),
    .i_b        (b_in),
    .i_cin0     (cin0),
`ifdef SERIAL_ADD_SUB_EN
    .i_sub      (sub),
`endif
    .o_fa_a     (fa_a),
    .o_fa_b     (fa_b),
    .o_fa_cin   (fa_cin),
    .i_fa_s     (fa_s),
    .i_fa_cout  (fa_cout),
    .o_busy     (busy),
    .o_done     (done),
    .o_s        (s_out),
    .o_cout     (cout),
    .o_overflow (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] eff_b(input logic [WIDTH-1:0] b, input logic sb);
`ifdef SERIAL_ADD_SUB_EN
    return sb ? ~b : b;
`else
    return b;
`endif
  endfunction

  function automatic logic eff_cin(input logic c, input logic sb);
`ifdef SERIAL_ADD_SUB_EN
    return sb ? 1'b1 : c;
`else
    return c;
`endif
  endfunction

  // Carry entering bit i = bit i of the sum of the operands' low i bits plus carry-in.
  function automatic logic carry_at(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bb,
                                    input logic c, input int i);
    logic [WIDTH:0] m, t;
    m = '0;
    for (int j = 0; j < i; j++) m[j] = 1'b1;
    t = ({1'b0, a} & m) + ({1'b0, bb} & m) + {{WIDTH{1'b0}}, c};
    return t[i];
  endfunction

  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                       input logic sb, output logic [WIDTH-1:0] s, output logic co, output logic ov);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    bb   = eff_b(b, sb);
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, eff_cin(c, sb)};
    s    = full[WIDTH-1:0];
    co   = full[WIDTH];
    ov   = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endtask

  task automatic begin_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic sb);
    a_in  = a;
    b_in  = b;
    cin0  = c;
    sub   = sb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Checks WIDTH SHIFT cycles; optionally pulses Start (with junk operands) at cycle 'inject'.
  task automatic run_shift(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic c, input logic sb, input int inject);
    logic [WIDTH-1:0] bb;
    logic [2:0]       exp_fa;
    bb = eff_b(b, sb);
    for (int i = 0; i < WIDTH; i++) begin
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
        n_bad++;
        $display("FAIL shift_busy cyc=%0d busy/done=%b expected=10", i, {busy, done});
      end
      exp_fa = {a[i], bb[i], carry_at(a, bb, eff_cin(c, sb), i)};
      n_cmp++;
      if ({fa_a, fa_b, fa_cin} !== exp_fa) begin
        n_bad++;
        $display("FAIL shift_fa cyc=%0d got=%b expected=%b", i, {fa_a, fa_b, fa_cin}, exp_fa);
      end
      n_cmp++;
      if ({s_out, cout, ovf} !== {last_s, last_cout, last_ovf}) begin
        n_bad++;
        $display("FAIL result_held cyc=%0d got=%b expected=%b", i, {s_out, cout, ovf},
                 {last_s, last_cout, last_ovf});
      end
      if (i == inject) begin
        a_in  = WIDTH'($urandom);
        b_in  = WIDTH'($urandom);
        cin0  = 1'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  task automatic check_done(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c, input logic sb);
    logic [WIDTH-1:0] es;
    logic             eco, eov;
    model(a, b, c, sb, es, eco, eov);
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_bad++;
      $display("FAIL done_pulse busy/done=%b expected=01", {busy, done});
    end
    n_cmp++;
    if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
      n_bad++;
      $display("FAIL done_fa got=%b expected=000", {fa_a, fa_b, fa_cin});
    end
    n_cmp++;
    if ({s_out, cout, ovf} !== {es, eco, eov}) begin
      n_bad++;
      $display("FAIL result a=%h b=%h cin=%b sub=%b got s=%h co=%b ov=%b expected s=%h co=%b ov=%b",
               a, b, c, sb, s_out, cout, ovf, es, eco, eov);
    end
    last_s    = es;
    last_cout = eco;
    last_ovf  = eov;
  endtask

  task automatic check_idle(input string tag);
    n_cmp++;
    if ({busy, done, fa_a, fa_b, fa_cin} !== 5'b00000) begin
      n_bad++;
      $display("FAIL %s ctrl got=%b expected=00000", tag, {busy, done, fa_a, fa_b, fa_cin});
    end
    n_cmp++;
    if ({s_out, cout, ovf} !== {last_s, last_cout, last_ovf}) begin
      n_bad++;
      $display("FAIL %s result got=%b expected=%b", tag, {s_out, cout, ovf},
               {last_s, last_cout, last_ovf});
    end
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic sb);
    begin_op(a, b, c, sb);
    run_shift(a, b, c, sb, -1);
    check_done(a, b, c, sb);
    tick();
    check_idle("after_done");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a_in  = '1;
    b_in  = '1;
    cin0  = 1'b1;
    sub   = 1'b0;
    tick();
    tick();
    start     = 1'b0;
    last_s    = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");
  endtask

  task automatic test_directed();
    do_op(4'b0011, 4'b0101, 1'b0, 1'b0);
    do_op(4'b1111, 4'b0001, 1'b0, 1'b0);
    do_op(4'b0111, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic sb;
    for (int k = 0; k < 16; k++) begin
`ifdef SERIAL_ADD_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), sb);
    end
  endtask

  task automatic test_start_ignored();
    logic [WIDTH-1:0] a, b;
    logic             c;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    c = 1'($urandom);
    begin_op(a, b, c, 1'b0);
    run_shift(a, b, c, 1'b0, 1);
    check_done(a, b, c, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle("single_done");
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    begin_op(a, b, 1'b0, 1'b0);
    run_shift(a, b, 1'b0, 1'b0, -1);
    check_done(a, b, 1'b0, 1'b0);
    begin_op(4'b0001, 4'b0001, 1'b0, 1'b0);
    run_shift(4'b0001, 4'b0001, 1'b0, 1'b0, -1);
    check_done(4'b0001, 4'b0001, 1'b0, 1'b0);
    n_cmp++;
    if (s_out !== 4'b0010) begin
      n_bad++;
      $display("FAIL b2b_sum got=%b expected=0010", s_out);
    end
    tick();
    check_idle("b2b_idle");
  endtask

  task automatic test_abort();
    begin_op(4'b0110, 4'b0111, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    last_s    = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    check_idle("abort_reset");
    for (int k = 0; k < WIDTH + 1; k++) begin
      tick();
      check_idle("abort_no_done");
    end
    do_op(4'b1001, 4'b0110, 1'b1, 1'b0);
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    do_op(4'b0101, 4'b0011, 1'b0, 1'b1);
    do_op(4'b1000, 4'b0001, 1'b1, 1'b1);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin0  = 1'b0;
    sub   = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_abort();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Bit-serial add sequencer that sits directly around the 1-bit full adder cell: drives its A/B/Cin inputs and consumes its S/Cout outputs.
- Turns one full-adder instance into a WIDTH-bit adder over WIDTH clock cycles. The carry is held in a flip-flop between cycles.
- Used by the datapath as the area-minimal ALU add path.
- Start/Busy/Done handshake towards the controller.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst_n  input  1  synchronous active-low reset
Start  input  1  request; sampled only in IDLE or DONE
A  input  WIDTH  first operand, captured when Start accepted
B  input  WIDTH  second operand, captured when Start accepted
Cin0  input  1  initial carry-in, captured when Start accepted
FA_A  output  1  bit to full adder A input
FA_B  output  1  bit to full adder B input
FA_Cin  output  1  carry to full adder Cin input
FA_S  input  1  sum bit returned by full adder
FA_Cout  input  1  carry-out returned by full adder
Busy  output  1  high while serial addition in progress
Done  output  1  one-cycle pulse: result valid
S  output  WIDTH  registered sum, held until next completion
Cout  output  1  registered final carry-out
Overflow  output  1  registered signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (Rst_n=0 at edge): state IDLE; counter, shift registers and carry flop 0; S=0, Cout=0, Overflow=0, Busy=0, Done=0. Overrides all other inputs, including mid-operation: the operation is aborted and no Done is issued.
- States and transitions:
  - IDLE -> SHIFT on Start=1.
  - SHIFT -> SHIFT while count < WIDTH-1.
  - SHIFT -> DONE at the edge processing bit WIDTH-1.
  - DONE -> SHIFT if Start=1, else DONE -> IDLE.
- Start accept (edge 0): a_sh<=A, b_sh<=B, carry_q<=Cin0, count<=0, state<=SHIFT.
- SHIFT, combinational outputs: FA_A=a_sh[0], FA_B=b_sh[0], FA_Cin=carry_q.
- SHIFT, each edge:
  - a_sh and b_sh shift right by 1.
  - s_sh shifts right with FA_S entering at bit WIDTH-1.
  - carry_q<=FA_Cout; count++.
  - When count==WIDTH-1, the msb_cin flop captures carry_q (carry into MSB).
- Completion edge (edge WIDTH):
  - S<={FA_S, s_sh[WIDTH-1:1]}, Cout<=FA_Cout, Overflow<=carry_q XOR FA_Cout.
  - State<=DONE.
- Latency: Start sampled at edge 0; Done high in the cycle between edges WIDTH and WIDTH+1, i.e. WIDTH+1 cycles from Start to observable result.
- Busy=1 exactly in SHIFT (WIDTH cycles). Done=1 exactly in DONE (1 cycle). Busy and Done are never high together.
- FA_A/FA_B/FA_Cin are 0 in IDLE and DONE.
- Start while in SHIFT: ignored; operands are not recaptured and there is no queueing.
- Start in the DONE cycle: accepted (back-to-back); next Done follows WIDTH+1 cycles later.
- S/Cout/Overflow change only at a completion edge or reset; they are stable otherwise.
- Arithmetic: modulo 2^WIDTH. The result equals A+B+Cin0 truncated to WIDTH; Cout is bit WIDTH of that sum.
- Full adder is external and purely combinational; the same-cycle loop FA_* -> FA_S/FA_Cout -> flops is the intended timing path.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- When defined:
  - Extra input port Sub (1 bit), captured with Start.
  - If Sub=1: b_sh<=~B and carry_q<=1 (Cin0 ignored), giving A-B in two's complement.
  - Cout=1 means no borrow. Overflow uses the same rule.
- When undefined: no Sub port, add-only behaviour as above.

Test Plan:
- Reset then A=0011, B=0101, Cin0=0, Start pulse -> Busy high 4 cycles, Done at cycle 5; S=1000, Cout=0, Overflow=1.
- A=1111, B=0001, Cin0=0 -> S=0000, Cout=1, Overflow=0. A=0111, B=0000, Cin0=1 -> S=1000, Cout=0, Overflow=1.
- Start during SHIFT with different A/B -> ignored; first result unchanged, exactly one Done.
- Start held high across DONE with A=0001, B=0001 after prior op -> second op begins without IDLE cycle; S=0010 five cycles later.
- Rst_n=0 at SHIFT cycle 2 -> next cycle all outputs 0, state IDLE, no Done; a subsequent normal op completes correctly.
- SERIAL_ADD_SUB_EN defined: A=0101, B=0011, Sub=1 -> S=0010, Cout=1, Overflow=0. A=1000, B=0001, Sub=1 -> S=0111, Overflow=1.
